// File: rtl/int_ctrl_if.sv
// Interrupt controller bus: IRQ lines and AP_ctrl handshake in, stack control out.
interface int_ctrl_if #(
    parameter int NUM_IRQ        = 4,
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int STACK_DEPTH    = 8
);
    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int DW  = $clog2(STACK_DEPTH) + 1;

    logic [NUM_IRQ-1:0]        irq;
    logic [NUM_IRQ-1:0]        irq_mask;
    logic                      int_ack;
    logic                      int_ret;
    logic                      int_req;
    logic [IDW-1:0]            int_id;
    logic [ADDR_WIDTH_MEM-1:0] int_vec_addr;
    logic                      int_set;
    logic                      ret_valid;
    logic [DW-1:0]             nest_depth;
    logic                      stack_full;
    logic                      int_err;

    modport master (
        output irq, irq_mask, int_ack, int_ret,
        input  int_req, int_id, int_vec_addr, int_set, ret_valid,
               nest_depth, stack_full, int_err
    );

    modport slave (
        input  irq, irq_mask, int_ack, int_ret,
        output int_req, int_id, int_vec_addr, int_set, ret_valid,
               nest_depth, stack_full, int_err
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects and prioritises IRQs, handshakes with
// AP_ctrl, and drives push/pop of the interrupt context stack.
module int_ctrl #(
    parameter int                        NUM_IRQ        = 4,
    parameter int                        ADDR_WIDTH_MEM = 16,
    parameter int                        STACK_DEPTH    = 8,
    parameter logic [ADDR_WIDTH_MEM-1:0] VEC_BASE       = 'h0100,
    parameter logic [ADDR_WIDTH_MEM-1:0] VEC_STRIDE     = 'h0010,
    parameter int                        SETTLE_CYC     = 2
) (
    input logic       clk,
    input logic       rst,
    int_ctrl_if.slave bus
);
    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int DW  = $clog2(STACK_DEPTH) + 1;
    localparam int SW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [NUM_IRQ-1:0]             irq_dly_q;
    logic [NUM_IRQ-1:0]             pend_q, pend_d;
    logic                           req_q, req_d;
    logic [IDW-1:0]                 id_q, id_d;
    logic [ADDR_WIDTH_MEM-1:0]      vec_q, vec_d;
    logic                           set_q, set_d;
    logic                           retv_q, retv_d;
    logic                           err_q, err_d;
    logic                           retp_q, retp_d;
    logic [DW-1:0]                  depth_q, depth_d;
    logic [STACK_DEPTH-1:0][IDW-1:0] prio_q, prio_d;

    logic [NUM_IRQ-1:0] rise, avail, id_oh;
    logic [IDW-1:0]     cand, cur_prio;
    logic [SW-1:0]      top_idx;
    logic               accept;

    assign rise     = bus.irq & ~irq_dly_q;
    assign avail    = pend_q & ~bus.irq_mask;
    assign id_oh    = NUM_IRQ'(1) << id_q;
    assign top_idx  = SW'(depth_q - DW'(1));
    assign cur_prio = prio_q[top_idx];
    assign accept   = (|avail) && (depth_q < DW'(STACK_DEPTH)) &&
                      ((depth_q == '0) || (cand < cur_prio));

    // Lowest unmasked pending index wins arbitration.
    always_comb begin
        cand = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (avail[i]) cand = IDW'(i);
        end
    end

    // Next-state logic: returns beat requests; one return can be queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q | rise;
        req_d   = req_q;
        id_d    = id_q;
        vec_d   = vec_q;
        set_d   = set_q;
        retv_d  = 1'b0;
        err_d   = 1'b0;
        retp_d  = retp_q;
        depth_d = depth_q;
        prio_d  = prio_q;

        // Outside IDLE a return is parked; a second one overflows the slot.
        if (state_q != IDLE && bus.int_ret) begin
            if (retp_q) err_d  = 1'b1;
            else        retp_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (retp_q || bus.int_ret) begin
                    // Servicing the parked return; a fresh one takes its slot.
                    retp_d = retp_q && bus.int_ret;
                    if (depth_q != '0) begin
                        retv_d  = 1'b1;
                        depth_d = depth_q - DW'(1);
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (accept) begin
                    id_d    = cand;
                    vec_d   = VEC_BASE + ADDR_WIDTH_MEM'(cand) * VEC_STRIDE;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // id/vec stay frozen here regardless of pending or mask changes.
                if (bus.int_ack) begin
                    req_d            = 1'b0;
                    set_d            = ~set_q;
                    pend_d           = (pend_q & ~id_oh) | rise;
                    prio_d[SW'(depth_q)] = id_q;
                    depth_d          = depth_q + DW'(1);
                    cnt_d            = '0;
                    state_d          = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) state_d = IDLE;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; the edge detector keeps tracking through reset.
    always_ff @(posedge clk) begin
        irq_dly_q <= bus.irq;
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            req_q   <= 1'b0;
            id_q    <= '0;
            vec_q   <= '0;
            set_q   <= 1'b0;
            retv_q  <= 1'b0;
            err_q   <= 1'b0;
            retp_q  <= 1'b0;
            depth_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
            set_q   <= set_d;
            retv_q  <= retv_d;
            err_q   <= err_d;
            retp_q  <= retp_d;
            depth_q <= depth_d;
            prio_q  <= prio_d;
        end
    end

    assign bus.int_req      = req_q;
    assign bus.int_id       = id_q;
    assign bus.int_vec_addr = vec_q;
    assign bus.int_set      = set_q;
    assign bus.ret_valid    = retv_q;
    assign bus.int_err      = err_q;
    assign bus.nest_depth   = depth_q;
    assign bus.stack_full   = (depth_q == DW'(STACK_DEPTH));
endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: stimulus queues expected events/snapshots,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_int_ctrl;
    localparam int NI = 16;
    localparam int AW = 16;
    localparam int SD = 8;

    typedef enum logic [1:0] {K_REQ, K_SET, K_RET, K_ERR} kind_t;
    typedef struct {
        kind_t kind;
        int    id;
        int    vec;
        int    depth;
        int    cyc;
    } exp_t;
    typedef struct {
        int req;
        int set;
        int depth;
        int full;
        int chk_iv;
        int id;
        int vec;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done = 1'b0;
    logic tmo = 1'b0;
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;
    int   set_exp = 0;
    exp_t  exp_q[$];
    snap_t snap_q[$];

    int_ctrl_if #(.NUM_IRQ(NI), .ADDR_WIDTH_MEM(AW), .STACK_DEPTH(SD)) bus();

    int_ctrl #(
        .NUM_IRQ(NI), .ADDR_WIDTH_MEM(AW), .STACK_DEPTH(SD),
        .VEC_BASE(16'h0100), .VEC_STRIDE(16'h0010), .SETTLE_CYC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (20000) @(posedge clk);
        tmo = 1'b1;
    end

    function automatic int vec_of(input int id);
        return 'h100 + id * 'h10;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input kind_t k, input int id, input int v, input int d, input int c);
        exp_t e;
        e.kind = k; e.id = id; e.vec = v; e.depth = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_snap(input int req, input int st, input int d, input int full,
                             input int chk_iv, input int id, input int v);
        snap_t s;
        s.req = req; s.set = st; s.depth = d; s.full = full;
        s.chk_iv = chk_iv; s.id = id; s.vec = v;
        snap_q.push_back(s);
    endtask

    task automatic wait_req();
        for (int k = 0; k < 30 && !bus.int_req; k++) tick(1);
    endtask

    task automatic do_ack(input int d);
        push_ev(K_SET, 0, 0, d, -1);
        set_exp ^= 1;
        wait_req();
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
        tick(3);
    endtask

    task automatic pulse_ret(input kind_t k, input int d);
        push_ev(k, 0, 0, d, -1);
        bus.int_ret = 1'b1;
        tick(1);
        bus.int_ret = 1'b0;
    endtask

    initial begin
        bus.irq      = '0;
        bus.irq_mask = '0;
        bus.int_ack  = 1'b0;
        bus.int_ret  = 1'b0;
        tick(3);
        push_snap(0, 0, 0, 0, 1, 0, 0);
        rst = 1'b0;
        tick(1);
        push_snap(0, 0, 0, 0, 1, 0, 0);
        tick(1);

        // 1: single IRQ, 2-cycle latency, vector 0x120
        push_ev(K_REQ, 2, 16'h0120, 0, cyc + 2);
        bus.irq[2] = 1'b1;
        do_ack(1);
        bus.irq[2] = 1'b0;

        // 2: preemption by irq0, then irq3 only pends
        push_ev(K_REQ, 0, 16'h0100, 1, -1);
        bus.irq[0] = 1'b1;
        do_ack(2);
        bus.irq[0] = 1'b0;
        bus.irq[3] = 1'b1;
        tick(8);
        push_snap(0, set_exp, 2, 0, 0, 0, 0);

        // 3: unwind two levels, then pending irq3 gets served
        pulse_ret(K_RET, 1);
        tick(4);
        push_snap(0, set_exp, 1, 0, 0, 0, 0);
        pulse_ret(K_RET, 0);
        push_ev(K_REQ, 3, 16'h0130, 0, -1);
        do_ack(1);
        bus.irq[3] = 1'b0;
        pulse_ret(K_RET, 0);
        tick(4);

        // 4: return with nothing in service
        pulse_ret(K_ERR, 0);
        tick(4);
        push_snap(0, set_exp, 0, 0, 0, 0, 0);

        // masked source keeps its pending edge until unmasked
        bus.irq_mask[5] = 1'b1;
        bus.irq[5] = 1'b1;
        tick(6);
        push_snap(0, set_exp, 0, 0, 0, 0, 0);
        push_ev(K_REQ, 5, 16'h0150, 0, -1);
        bus.irq_mask[5] = 1'b0;
        do_ack(1);
        bus.irq[5] = 1'b0;
        pulse_ret(K_RET, 0);
        tick(4);

        // 5: fill the stack with rising priority, full blocks, pop re-enables
        for (int k = 0; k < SD; k++) begin
            push_ev(K_REQ, 15 - k, vec_of(15 - k), k, -1);
            bus.irq[15 - k] = 1'b1;
            do_ack(k + 1);
        end
        push_snap(0, set_exp, 8, 1, 0, 0, 0);
        bus.irq[7] = 1'b1;
        tick(6);
        push_snap(0, set_exp, 8, 1, 0, 0, 0);
        pulse_ret(K_RET, 7);
        push_ev(K_REQ, 7, 16'h0170, 7, -1);
        do_ack(8);
        bus.irq = '0;
        for (int d = SD - 1; d >= 0; d--) begin
            pulse_ret(K_RET, d);
            tick(3);
        end
        push_snap(0, set_exp, 0, 0, 0, 0, 0);

        // 6: reset mid-request, held line does not re-trigger
        push_ev(K_REQ, 1, 16'h0110, 0, -1);
        bus.irq[1] = 1'b1;
        wait_req();
        tick(1);
        rst = 1'b1;
        tick(2);
        set_exp = 0;
        push_snap(0, 0, 0, 0, 1, 0, 0);
        tick(1);
        rst = 1'b0;
        tick(8);
        push_snap(0, 0, 0, 0, 1, 0, 0);
        bus.irq[1] = 1'b0;
        tick(2);
        push_ev(K_REQ, 1, 16'h0110, 0, -1);
        bus.irq[1] = 1'b1;
        do_ack(1);
        pulse_ret(K_RET, 0);
        tick(4);
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    function automatic void cmp(input string nm, input int act, input int req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, req, req);
        end
    endfunction

    task automatic got(input kind_t k);
        exp_t e;
        if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_%s: got event at depth %0d, required none", k.name(), bus.nest_depth);
            return;
        end
        e = exp_q.pop_front();
        cmp("event_kind", int'(k), int'(e.kind));
        cmp({k.name(), "_depth"}, int'(bus.nest_depth), e.depth);
        if (k == K_REQ) begin
            cmp("req_id", int'(bus.int_id), e.id);
            cmp("req_vec", int'(bus.int_vec_addr), e.vec);
            if (e.cyc >= 0) cmp("req_latency_cycle", cyc, e.cyc);
        end
    endtask

    initial begin
        logic  prev_req;
        logic  prev_set;
        snap_t s;
        exp_t  e;
        prev_req = 1'b0;
        prev_set = 1'b0;
        forever begin
            @(negedge clk);
            if (tmo) begin
                vecs++;
                errs++;
                $display("FAIL watchdog: got no end of stimulus, required done within budget");
                $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
                $finish;
            end
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                cmp("snap_int_req", int'(bus.int_req), s.req);
                cmp("snap_int_set", int'(bus.int_set), s.set);
                cmp("snap_nest_depth", int'(bus.nest_depth), s.depth);
                cmp("snap_stack_full", int'(bus.stack_full), s.full);
                if (s.chk_iv != 0) begin
                    cmp("snap_int_id", int'(bus.int_id), s.id);
                    cmp("snap_vec", int'(bus.int_vec_addr), s.vec);
                    cmp("snap_ret_valid", int'(bus.ret_valid), 0);
                    cmp("snap_int_err", int'(bus.int_err), 0);
                end
            end
            if (rst) begin
                prev_req = 1'b0;
                prev_set = bus.int_set;
            end else begin
                if (bus.int_set != prev_set) got(K_SET);
                if (bus.ret_valid) got(K_RET);
                if (bus.int_err) got(K_ERR);
                if (bus.int_req && !prev_req) got(K_REQ);
                prev_req = bus.int_req;
                prev_set = bus.int_set;
            end
            if (done) begin
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    vecs++;
                    errs++;
                    $display("FAIL missing_%s: got no event, required one at depth %0d", e.kind.name(), e.depth);
                end
                $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
                $finish;
            end
        end
    end
endmodule
